// File: rtl/gpio_key_led_seq.sv
// APB master that sets up a GPIO slave, polls four active-low keys and toggles four LEDs on presses.
// Optional macro GPIO_SEQ_DEBOUNCE_EN: a key change is accepted only after two identical polls.
module gpio_key_led_seq #(
  parameter int unsigned POLL_DIV  = 1000,
  parameter logic [31:0] GPIO_BASE = 32'h0000_0000
) (
  input  logic        iPCLK,
  input  logic        iPRESETn,
  output logic [31:0] oPADDR,
  output logic        oPSEL,
  output logic        oPENABLE,
  output logic        oPWRITE,
  output logic [31:0] oPWDATA,
  input  logic        iPREADY,
  input  logic [31:0] iPRDATA,
  output logic [3:0]  oLED,
  output logic        oBUSY
);

  localparam logic [31:0] ADDR_DATA_RO = GPIO_BASE + 32'h0;
  localparam logic [31:0] ADDR_DATA    = GPIO_BASE + 32'h4;
  localparam logic [31:0] ADDR_DIRM    = GPIO_BASE + 32'h8;
  localparam logic [31:0] ADDR_OEN     = GPIO_BASE + 32'hC;
  localparam logic [31:0] LED_MASK     = 32'h0000_00F0;
  localparam logic [15:0] POLL_LOAD    = 16'(POLL_DIV - 1);

  typedef enum logic [2:0] {
    ST_INIT_DIRM,
    ST_INIT_OEN,
    ST_WAIT,
    ST_POLL,
    ST_EVAL,
    ST_UPDATE
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } phase_e;

  state_e      state_q;
  phase_e      phase_q;
  logic [31:0] paddr_q;
  logic        psel_q;
  logic        penable_q;
  logic        pwrite_q;
  logic [31:0] pwdata_q;
  logic [3:0]  led_q;
  logic [3:0]  kprev_q;
  logic [3:0]  smp_q;
  logic [15:0] cnt_q;
`ifdef GPIO_SEQ_DEBOUNCE_EN
  logic [3:0]  prv_q;
`endif

  logic [3:0] kst;
  logic [3:0] press;
  logic [3:0] led_d;

  // Only the key nibble of the read data is ever used.
  logic unused_prdata;
  assign unused_prdata = ^iPRDATA[31:4];

  always_comb begin
    kst = smp_q;
`ifdef GPIO_SEQ_DEBOUNCE_EN
    kst = (smp_q & ~(smp_q ^ prv_q)) | (kprev_q & (smp_q ^ prv_q));
`endif
    press = kprev_q & ~kst;
    led_d = led_q ^ press;
  end

  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      state_q   <= ST_INIT_DIRM;
      phase_q   <= PH_IDLE;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      led_q     <= '0;
      kprev_q   <= '1;
      smp_q     <= '1;
      cnt_q     <= '0;
`ifdef GPIO_SEQ_DEBOUNCE_EN
      prv_q     <= '1;
`endif
    end else begin
      case (state_q)
        ST_INIT_DIRM, ST_INIT_OEN, ST_POLL, ST_UPDATE: begin
          case (phase_q)
            PH_IDLE: begin
              // Only the init writes start from an idle cycle; POLL and UPDATE launch straight into SETUP.
              case (state_q)
                ST_INIT_DIRM: begin
                  paddr_q   <= ADDR_DIRM;
                  pwrite_q  <= 1'b1;
                  pwdata_q  <= LED_MASK;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  phase_q   <= PH_SETUP;
                end
                ST_INIT_OEN: begin
                  paddr_q   <= ADDR_OEN;
                  pwrite_q  <= 1'b1;
                  pwdata_q  <= LED_MASK;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  phase_q   <= PH_SETUP;
                end
                default: ;
              endcase
            end
            PH_SETUP: begin
              penable_q <= 1'b1;
              phase_q   <= PH_ACCESS;
            end
            PH_ACCESS: begin
              if (iPREADY) begin
                psel_q    <= 1'b0;
                penable_q <= 1'b0;
                phase_q   <= PH_IDLE;
                case (state_q)
                  ST_INIT_DIRM: state_q <= ST_INIT_OEN;
                  ST_POLL: begin
                    smp_q   <= iPRDATA[3:0];
                    state_q <= ST_EVAL;
                  end
                  default: begin
                    cnt_q   <= POLL_LOAD;
                    state_q <= ST_WAIT;
                  end
                endcase
              end
            end
            default: phase_q <= PH_IDLE;
          endcase
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q   <= ST_POLL;
            phase_q   <= PH_SETUP;
            paddr_q   <= ADDR_DATA_RO;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_EVAL: begin
          kprev_q <= kst;
          led_q   <= led_d;
`ifdef GPIO_SEQ_DEBOUNCE_EN
          prv_q   <= smp_q;
`endif
          if (press != '0) begin
            state_q   <= ST_UPDATE;
            phase_q   <= PH_SETUP;
            paddr_q   <= ADDR_DATA;
            pwrite_q  <= 1'b1;
            pwdata_q  <= {24'h0, led_d, 4'h0};
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
          end else begin
            cnt_q   <= POLL_LOAD;
            state_q <= ST_WAIT;
          end
        end
        default: begin
          state_q <= ST_INIT_DIRM;
          phase_q <= PH_IDLE;
        end
      endcase
    end
  end

  assign oPADDR   = paddr_q;
  assign oPSEL    = psel_q;
  assign oPENABLE = penable_q;
  assign oPWRITE  = pwrite_q;
  assign oPWDATA  = pwdata_q;
  assign oBUSY    = psel_q;
  assign oLED     = led_q;

endmodule
